// File: rtl/aespim_ghash_mul_seq_if.sv
// Bundle of the control, result and partial-product datapath signals of the
// sequential GHASH multiplier. The slave side is the multiplier itself; the
// master side is whatever drives it and serves its partial-product requests.
interface aespim_ghash_mul_seq_if;
    logic         start_i;
    logic         abort_i;
    logic [127:0] op_a_i;
    logic [127:0] op_b_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] result_o;
    logic         pp_req_o;
    logic         pp_gnt_i;
    logic [31:0]  pp_a_o;
    logic [31:0]  pp_b_o;
    logic [2:0]   pp_shift_o;
    logic         pp_rsp_valid_i;
    logic [31:0]  pp_c0_i;
    logic [31:0]  pp_c1_i;
    logic [5:0]   pp_c3_i;

    modport slave (
        input  start_i, abort_i, op_a_i, op_b_i,
        input  pp_gnt_i, pp_rsp_valid_i, pp_c0_i, pp_c1_i, pp_c3_i,
        output busy_o, done_o, result_o,
        output pp_req_o, pp_a_o, pp_b_o, pp_shift_o
    );

    modport master (
        output start_i, abort_i, op_a_i, op_b_i,
        output pp_gnt_i, pp_rsp_valid_i, pp_c0_i, pp_c1_i, pp_c3_i,
        input  busy_o, done_o, result_o,
        input  pp_req_o, pp_a_o, pp_b_o, pp_shift_o
    );
endinterface

// File: rtl/aespim_ghash_mul_seq.sv
// Sequential 128x128 GHASH multiply built from 16 word-pair partial products.
// Each pair (i,j) is handed to a shared clmul32/reduce datapath; the reduced
// response is XOR-folded into a 128-bit accumulator at a word position set by
// the pair shift s = i + j.
//
// state  | meaning
// IDLE   | waiting for start_i; operands captured on accept
// ISSUE  | pp_req_o high for pair k until granted
// WAIT   | request granted, waiting for the reduced response of pair k
// DONE   | one-cycle done_o pulse, result_o holds the finished product
module aespim_ghash_mul_seq (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    aespim_ghash_mul_seq_if.slave      bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] op_a_q, op_b_q;
    logic [127:0] acc_q, acc_d;
    logic [127:0] result_q;
    logic [3:0]   k_q;
    logic [1:0]   wi, wj;
    logic [2:0]   shift;
    logic [1:0]   c0_w, c1_w;
    logic         start_acc, rsp_acc;

    assign wi    = k_q[3:2];
    assign wj    = k_q[1:0];
    assign shift = {1'b0, wi} + {1'b0, wj};
    // Word targets repeat with period 4 in s: C0 lands on s mod 4, C1 one above.
    assign c0_w  = shift[1:0];
    assign c1_w  = shift[1:0] + 2'd1;

    // Abort blocks both accepting a start and absorbing a response.
    assign start_acc = (state_q == S_IDLE) && bus.start_i && !bus.abort_i;
    assign rsp_acc   = (state_q == S_WAIT) && bus.pp_rsp_valid_i && !bus.abort_i;

    // Fold the current response into the accumulator; XOR order is irrelevant.
    always_comb begin
        acc_d = acc_q;
        acc_d[32*c0_w +: 32] = acc_d[32*c0_w +: 32] ^ bus.pp_c0_i;
        acc_d[32*c1_w +: 32] = acc_d[32*c1_w +: 32] ^ bus.pp_c1_i;
        if (shift >= 3'd3) begin
            acc_d[31:0] = acc_d[31:0] ^ {26'd0, bus.pp_c3_i};
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (bus.abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start_i) state_d = S_ISSUE;
                S_ISSUE: if (bus.pp_gnt_i) state_d = S_WAIT;
                S_WAIT:  if (bus.pp_rsp_valid_i) state_d = (k_q == 4'd15) ? S_DONE : S_ISSUE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore-style status outputs; done is suppressed by a same-cycle abort.
    always_comb begin
        bus.busy_o   = (state_q != S_IDLE);
        bus.done_o   = (state_q == S_DONE) && !bus.abort_i;
        bus.pp_req_o = (state_q == S_ISSUE);
    end

    // Operand capture, accumulation, pair counter and result publication.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else if (start_acc) begin
            op_a_q <= bus.op_a_i;
            op_b_q <= bus.op_b_i;
            acc_q  <= '0;
            k_q    <= '0;
        end else if (rsp_acc) begin
            acc_q <= acc_d;
            k_q   <= k_q + 4'd1;
            if (k_q == 4'd15) begin
                result_q <= acc_d;
            end
        end
    end

    assign bus.result_o   = result_q;
    assign bus.pp_a_o     = op_a_q[32*wi +: 32];
    assign bus.pp_b_o     = op_b_q[32*wj +: 32];
    assign bus.pp_shift_o = shift;

endmodule

// File: tb/tb_aespim_ghash_mul_seq.sv
// Directed bench for the sequential GHASH multiplier with a behavioural
// partial-product datapath that grants and responds after programmable delays.
module tb_aespim_ghash_mul_seq;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    aespim_ghash_mul_seq_if bus();

    aespim_ghash_mul_seq dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_err = 0;
    int n_chk = 0;

    int gnt_lo = 0, gnt_hi = 0, rsp_lo = 1, rsp_hi = 1, dp_mode = 0;
    int          sh_q[$];
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];

    int exp_sh[16] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5, 3, 4, 5, 6};

    // Response content of the datapath stand-in: {c0, c1, c3}.
    function automatic logic [69:0] dp_resp(input logic [31:0] a, input logic [31:0] b,
                                            input int s, input int mode);
        logic [31:0] c0, c1, sv;
        logic [5:0]  c3;
        sv = 32'(s);
        c0 = '0; c1 = '0; c3 = '0;
        case (mode)
            1: c0 = (s == 0) ? 32'd1 : 32'd0;
            2: c3 = (s >= 3) ? 6'h3f : 6'h00;
            default: begin
                c0 = a ^ {b[15:0], b[31:16]} ^ sv;
                c1 = a + (b * 32'd3);
                c3 = a[5:0] ^ b[11:6] ^ sv[5:0];
            end
        endcase
        return {c0, c1, c3};
    endfunction

    // Reference accumulation over the 16 pairs using the word-target table.
    function automatic logic [127:0] ref_acc(input logic [127:0] a, input logic [127:0] b,
                                             input int mode);
        logic [127:0] r;
        logic [69:0]  p;
        int i, j, s, w0, w1;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            i = k / 4;
            j = k % 4;
            s = i + j;
            p = dp_resp(a[32*i +: 32], b[32*j +: 32], s, mode);
            case (s)
                0: begin w0 = 0; w1 = 1; end
                1: begin w0 = 1; w1 = 2; end
                2: begin w0 = 2; w1 = 3; end
                3: begin w0 = 3; w1 = 0; end
                4: begin w0 = 0; w1 = 1; end
                5: begin w0 = 1; w1 = 2; end
                default: begin w0 = 2; w1 = 3; end
            endcase
            r[32*w0 +: 32] = r[32*w0 +: 32] ^ p[69:38];
            r[32*w1 +: 32] = r[32*w1 +: 32] ^ p[37:6];
            if (s >= 3) r[31:0] = r[31:0] ^ {26'd0, p[5:0]};
        end
        return r;
    endfunction

    // Datapath stand-in: grant after gnt delay, respond after rsp delay.
    initial begin : dp_model
        int st, gcnt, rcnt;
        logic [69:0] r;
        st = 0; gcnt = 0; rcnt = 0; r = '0;
        bus.pp_gnt_i = 1'b0; bus.pp_rsp_valid_i = 1'b0;
        bus.pp_c0_i = '0; bus.pp_c1_i = '0; bus.pp_c3_i = '0;
        forever begin
            @(negedge clk_i or negedge rst_ni);
            bus.pp_gnt_i       = 1'b0;
            bus.pp_rsp_valid_i = 1'b0;
            bus.pp_c0_i        = 32'hdead_beef;
            bus.pp_c1_i        = 32'hcafe_f00d;
            bus.pp_c3_i        = 6'h2a;
            if (!rst_ni) begin
                st = 0;
            end else if (st == 2) begin
                rcnt--;
                if (rcnt <= 0) begin
                    bus.pp_rsp_valid_i = 1'b1;
                    bus.pp_c0_i = r[69:38];
                    bus.pp_c1_i = r[37:6];
                    bus.pp_c3_i = r[5:0];
                    st = 0;
                end
            end else if (!bus.pp_req_o) begin
                st = 0;
            end else begin
                if (st == 0) begin
                    gcnt = int'($urandom_range(32'(gnt_hi), 32'(gnt_lo)));
                    st = 1;
                end
                if (gcnt == 0) begin
                    bus.pp_gnt_i = 1'b1;
                    sh_q.push_back(int'(bus.pp_shift_o));
                    a_q.push_back(bus.pp_a_o);
                    b_q.push_back(bus.pp_b_o);
                    r = dp_resp(bus.pp_a_o, bus.pp_b_o, int'(bus.pp_shift_o), dp_mode);
                    rcnt = int'($urandom_range(32'(rsp_hi), 32'(rsp_lo)));
                    st = 2;
                end else begin
                    gcnt--;
                end
            end
        end
    end

    // Start one operation from IDLE and wait (bounded) for done_o.
    task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                          output logic [127:0] res, output int lat, output logic [127:0] mid);
        sh_q.delete(); a_q.delete(); b_q.delete();
        @(negedge clk_i);
        bus.op_a_i = a; bus.op_b_i = b; bus.start_i = 1'b1;
        lat = -1; mid = '0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk_i);
            bus.start_i = 1'b0;
            bus.op_a_i  = ~a;
            if (c == 10) mid = bus.result_o;
            if (bus.done_o) begin
                lat = c;
                break;
            end
        end
        res = bus.result_o;
    endtask

    task automatic test_reset();
        logic [127:0] exp;
        int seen;
        @(negedge clk_i);
        n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        n_chk++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
        n_chk++; if (bus.pp_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", bus.pp_req_o); end
        n_chk++; if (bus.result_o !== 128'd0) begin n_err++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
        // First start is taken on the very first edge after release.
        rst_ni = 1'b1;
        bus.op_a_i = '0; bus.op_b_i = '0; bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        n_chk++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL first_start_busy got=%b exp=1", bus.busy_o); end
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (bus.done_o) begin seen = 1; break; end
        end
        exp = ref_acc('0, '0, 0);
        n_chk++; if (seen != 1) begin n_err++; $display("FAIL first_start_done got=%0d exp=1", seen); end
        n_chk++; if (bus.result_o !== exp) begin n_err++; $display("FAIL first_start_result got=%h exp=%h", bus.result_o, exp); end
    endtask

    task automatic test_single();
        logic [127:0] res, mid;
        int lat;
        dp_mode = 1; gnt_lo = 0; gnt_hi = 0; rsp_lo = 1; rsp_hi = 1;
        run_op(128'd1, 128'd1, res, lat, mid);
        n_chk++; if (lat != 33) begin n_err++; $display("FAIL single_latency got=%0d exp=33", lat); end
        n_chk++; if (res !== 128'd1) begin n_err++; $display("FAIL single_result got=%h exp=1", res); end
        n_chk++; if (sh_q.size() != 16) begin n_err++; $display("FAIL single_npairs got=%0d exp=16", sh_q.size()); end
        for (int k = 0; k < 16 && k < sh_q.size(); k++) begin
            n_chk++;
            if (sh_q[k] != exp_sh[k] || a_q[k] !== ((k / 4 == 0) ? 32'd1 : 32'd0)
                || b_q[k] !== ((k % 4 == 0) ? 32'd1 : 32'd0)) begin
                n_err++;
                $display("FAIL single_pair%0d got s=%0d a=%h b=%h exp s=%0d", k, sh_q[k], a_q[k], b_q[k], exp_sh[k]);
            end
        end
        @(negedge clk_i);
        n_chk++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL single_done_width got=%b exp=0", bus.done_o); end
        n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_random();
        logic [127:0] a, b, res, mid, exp, prev;
        int lat;
        dp_mode = 0; gnt_lo = 0; gnt_hi = 5; rsp_lo = 1; rsp_hi = 5;
        for (int n = 0; n < 3; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            exp  = ref_acc(a, b, 0);
            prev = bus.result_o;
            run_op(a, b, res, lat, mid);
            n_chk++; if (lat < 33) begin n_err++; $display("FAIL rand%0d_latency got=%0d exp>=33", n, lat); end
            n_chk++; if (res !== exp) begin n_err++; $display("FAIL rand%0d_result got=%h exp=%h", n, res, exp); end
            n_chk++; if (mid !== prev) begin n_err++; $display("FAIL rand%0d_hidden_acc got=%h exp=%h", n, mid, prev); end
            n_chk++; if (sh_q.size() != 16) begin n_err++; $display("FAIL rand%0d_npairs got=%0d exp=16", n, sh_q.size()); end
            for (int k = 0; k < 16 && k < sh_q.size(); k++) begin
                n_chk++;
                if (sh_q[k] != exp_sh[k] || a_q[k] !== a[32*(k/4) +: 32] || b_q[k] !== b[32*(k%4) +: 32]) begin
                    n_err++;
                    $display("FAIL rand%0d_pair%0d got s=%0d a=%h b=%h exp s=%0d a=%h b=%h", n, k,
                             sh_q[k], a_q[k], b_q[k], exp_sh[k], a[32*(k/4) +: 32], b[32*(k%4) +: 32]);
                end
            end
        end
    endtask

    task automatic test_c3();
        logic [127:0] res, mid;
        int lat, n3;
        dp_mode = 2; gnt_lo = 0; gnt_hi = 3; rsp_lo = 1; rsp_hi = 3;
        run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, res, lat, mid);
        n3 = 0;
        foreach (sh_q[k]) if (sh_q[k] >= 3) n3++;
        n_chk++; if (lat < 33) begin n_err++; $display("FAIL c3_latency got=%0d exp>=33", lat); end
        n_chk++; if (n3 != 10) begin n_err++; $display("FAIL c3_pairs got=%0d exp=10", n3); end
        n_chk++; if (res[31:0] !== 32'd0) begin n_err++; $display("FAIL c3_word0 got=%h exp=0", res[31:0]); end
        n_chk++; if (res !== 128'd0) begin n_err++; $display("FAIL c3_result got=%h exp=0", res); end
    endtask

    task automatic test_abort();
        logic [127:0] a, b, prev, res, mid, exp;
        int found, seen, lat;
        dp_mode = 0; gnt_lo = 0; gnt_hi = 0; rsp_lo = 4; rsp_hi = 4;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        prev = bus.result_o;
        sh_q.delete(); a_q.delete(); b_q.delete();
        @(negedge clk_i);
        bus.op_a_i = a; bus.op_b_i = b; bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        found = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk_i);
            #1;
            if (sh_q.size() == 8) begin found = 1; break; end
        end
        n_chk++; if (found != 1) begin n_err++; $display("FAIL abort_reach_pair7 got=%0d exp=1", found); end
        @(negedge clk_i);
        bus.abort_i = 1'b1;
        @(negedge clk_i);
        bus.abort_i = 1'b0;
        n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.busy_o); end
        n_chk++; if (bus.pp_req_o !== 1'b0) begin n_err++; $display("FAIL abort_req got=%b exp=0", bus.pp_req_o); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (bus.done_o || bus.busy_o) seen = 1;
        end
        n_chk++; if (seen != 0) begin n_err++; $display("FAIL abort_late_rsp got=%0d exp=0", seen); end
        n_chk++; if (bus.result_o !== prev) begin n_err++; $display("FAIL abort_result got=%h exp=%h", bus.result_o, prev); end
        gnt_lo = 0; gnt_hi = 4; rsp_lo = 1; rsp_hi = 4;
        exp = ref_acc(b, a, 0);
        run_op(b, a, res, lat, mid);
        n_chk++; if (sh_q.size() != 16) begin n_err++; $display("FAIL abort_rerun_npairs got=%0d exp=16", sh_q.size()); end
        n_chk++; if (res !== exp) begin n_err++; $display("FAIL abort_rerun_result got=%h exp=%h", res, exp); end
    endtask

    task automatic test_start_held();
        logic [127:0] a1, a2, b1, exp;
        int seen;
        dp_mode = 0; gnt_lo = 0; gnt_hi = 0; rsp_lo = 1; rsp_hi = 1;
        a1 = {$urandom, $urandom, $urandom, $urandom};
        a2 = {$urandom, $urandom, $urandom, $urandom};
        b1 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk_i);
        bus.op_a_i = a1; bus.op_b_i = b1; bus.start_i = 1'b1;
        seen = 0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk_i);
            if (c == 5) bus.op_a_i = a2;
            if (bus.done_o) begin seen = 1; break; end
        end
        exp = ref_acc(a1, b1, 0);
        n_chk++; if (seen != 1) begin n_err++; $display("FAIL held_done1 got=%0d exp=1", seen); end
        n_chk++; if (bus.result_o !== exp) begin n_err++; $display("FAIL held_result1 got=%h exp=%h", bus.result_o, exp); end
        @(negedge clk_i);
        n_chk++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL held_done_width got=%b exp=0", bus.done_o); end
        n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL held_idle got=%b exp=0", bus.busy_o); end
        @(negedge clk_i);
        bus.start_i = 1'b0;
        n_chk++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL held_restart got=%b exp=1", bus.busy_o); end
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (bus.done_o) begin seen = 1; break; end
        end
        exp = ref_acc(a2, b1, 0);
        n_chk++; if (seen != 1) begin n_err++; $display("FAIL held_done2 got=%0d exp=1", seen); end
        n_chk++; if (bus.result_o !== exp) begin n_err++; $display("FAIL held_result2 got=%h exp=%h", bus.result_o, exp); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (bus.busy_o || bus.done_o) seen = 1;
        end
        n_chk++; if (seen != 0) begin n_err++; $display("FAIL held_no_third got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int found, seen;
        dp_mode = 0; gnt_lo = 5; gnt_hi = 5; rsp_lo = 1; rsp_hi = 1;
        @(negedge clk_i);
        bus.op_a_i = {4{32'h1234_5678}}; bus.op_b_i = {4{32'h9abc_def0}}; bus.start_i = 1'b1;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            bus.start_i = 1'b0;
            if (bus.pp_req_o) begin found = 1; break; end
        end
        n_chk++; if (found != 1) begin n_err++; $display("FAIL rstmid_req_seen got=%0d exp=1", found); end
        #1 rst_ni = 1'b0;
        #1;
        n_chk++; if (bus.pp_req_o !== 1'b0) begin n_err++; $display("FAIL rstmid_req got=%b exp=0", bus.pp_req_o); end
        n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy_o); end
        n_chk++; if (bus.result_o !== 128'd0) begin n_err++; $display("FAIL rstmid_result got=%h exp=0", bus.result_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (bus.busy_o || bus.done_o) seen = 1;
        end
        n_chk++; if (seen != 0) begin n_err++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.op_a_i  = '0;
        bus.op_b_i  = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        test_reset();
        test_single();
        test_random();
        test_c3();
        test_abort();
        test_start_held();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aespim_ghash_mul_seq.md
AESPIM_GHASH_MUL_SEQ -- requirements
Module: aespim_ghash_mul_seq

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  request new 128x128 multiply; sampled only in IDLE.
REQ-005 abort_i  input  1  cancel current operation; return to IDLE next cycle.
REQ-006 op_a_i, op_b_i  input  128 each  operands, word w = bits[32w+31:32w]; captured on accepted start.
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 done_o  output  1  single-cycle pulse, result_o valid.
REQ-009 result_o  output  128  accumulated product; held until next accepted start.
REQ-010 pp_req_o  output  1  partial-product request to the shared clmul32/reduce datapath.
REQ-011 pp_gnt_i  input  1  datapath accepts request this cycle (req & gnt = handshake).
REQ-012 pp_a_o, pp_b_o  output  32 each  operand words for the current pair.
REQ-013 pp_shift_o  output  3  shift index 0..6 for the current pair.
REQ-014 pp_rsp_valid_i  input  1  reduced result valid (one response per accepted request, in order).
REQ-015 pp_c0_i, pp_c1_i  input  32 each; pp_c3_i  input  6  reduced result words.

Function
REQ-016 States: IDLE, ISSUE, WAIT, DONE; encoding free, no other reachable states.
REQ-017 IDLE: on start_i=1 capture op_a_i/op_b_i, clear accumulator and pair counter k=0, go ISSUE next cycle.
REQ-018 Pair k (0..15): i=k[3:2], j=k[1:0]; pp_a_o=A word i, pp_b_o=B word j, pp_shift_o=i+j.
REQ-019 ISSUE: pp_req_o=1 with stable pp_a_o/pp_b_o/pp_shift_o until pp_gnt_i=1; on grant go WAIT.
REQ-020 WAIT: pp_req_o=0; on pp_rsp_valid_i=1 accumulate, then ISSUE with k+1, or DONE if k=15.
REQ-021 Accumulation for shift s, (C0 word, C1 word): 0:(0,1) 1:(1,2) 2:(2,3) 3:(3,0) 4:(0,1) 5:(1,2) 6:(2,3); XOR C0 and C1 into those words.
REQ-022 For s>=3, pp_c3_i zero-extended to 32 bits SHALL additionally be XORed into word 0 in the same cycle (after C1 XOR when C1 targets word 0).
REQ-023 pp_rsp_valid_i outside WAIT SHALL be ignored; pp_rsp_valid_i in the same cycle as grant SHALL NOT be accepted (minimum response latency 1).
REQ-024 DONE: done_o=1 for exactly one cycle, result_o = accumulator, go IDLE next cycle.
REQ-025 Total latency with gnt and response each after 1 cycle: start accept to done_o = 33 cycles (2 per pair + DONE).
REQ-026 start_i while busy_o=1 SHALL be ignored; no queueing.
REQ-027 abort_i has priority over all transitions; from ISSUE/WAIT/DONE go IDLE, done_o=0, result_o retains prior completed value; a response arriving after abort SHALL be ignored.
REQ-028 Accumulator not visible on result_o until DONE; result_o updates only entering DONE.

Reset
REQ-029 On rst_ni=0, immediately: state IDLE, busy_o=0, done_o=0, pp_req_o=0, result_o=0, k=0, operand registers 0.
REQ-030 Reset mid-operation discards all progress; no done_o after release.
REQ-031 First start_i is accepted on the first rising edge with rst_ni=1.

Verification
REQ-032 A=1, B=1 (word 0 only), gnt/rsp 1-cycle, model returns C0=1 for s=0, zeros otherwise -> done_o at cycle 33, result_o=0x...0001.
REQ-033 Random A/B, datapath model with random gnt (0-5 cycles) and rsp delay (1-5) -> 16 requests, shifts in order 0,1,2,3,1,2,3,4,2,3,4,5,3,4,5,6, result_o matches reference accumulation of REQ-021/022.
REQ-034 Model returns C0=C1=0, C3=0x3F for every s>=3 -> 10 such pairs, XOR parity even, result_o word0 = 0.
REQ-035 abort_i asserted in WAIT of pair 7, then rsp_valid -> IDLE next cycle, no done_o, result_o unchanged, next start runs full 16 pairs.
REQ-036 start_i held high throughout and while busy -> exactly one operation per IDLE visit, done_o pulse width 1.
REQ-037 rst_ni low during ISSUE with pp_req_o=1 -> pp_req_o=0 and busy_o=0 asynchronously, result_o=0.
